noc_axi4_bridge_resp_arb: RTL

Two-requester arbiter that shares the NoC response serializer between the AXI4 read-response path and the write-response path of the NoC-AXI4 bridge. It accepts one response per handshake from each path, picks a winner by round-robin (or fixed read priority), and holds the winner in a single registered output slot. That slot drives the serializer's header/data/valid inputs and obeys its ready.

---
 rtl/noc_axi4_bridge_resp_arb.sv | 71 +++++++
 1 files changed

// File: rtl/noc_axi4_bridge_resp_arb.sv
// Arbitrates the bridge's AXI4 read- and write-response paths onto the single
// NoC response serializer through one registered output slot.
module noc_axi4_bridge_resp_arb #(
    parameter bit          FAIR             = 1'b1,
    parameter int unsigned MSG_HEADER_WIDTH = 192,
    parameter int unsigned AXI4_DATA_WIDTH  = 512
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [MSG_HEADER_WIDTH-1:0] rd_header_in,
    input  logic [AXI4_DATA_WIDTH-1:0]  rd_data_in,
    input  logic                        rd_val,
    output logic                        rd_rdy,
    input  logic [MSG_HEADER_WIDTH-1:0] wr_header_in,
    input  logic                        wr_val,
    output logic                        wr_rdy,
    output logic [MSG_HEADER_WIDTH-1:0] header_out,
    output logic [AXI4_DATA_WIDTH-1:0]  data_out,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic                        grant_src
);

    localparam int unsigned HW = MSG_HEADER_WIDTH;
    localparam int unsigned DW = AXI4_DATA_WIDTH;

    logic load_en;
    logic rd_pref;
    logic last_wr;
    logic rd_acc;
    logic wr_acc;

    // Readies ignore the requester's own valid; rd_pref says who wins a tie.
    always_comb begin
        load_en = ~out_val | out_rdy;
        rd_pref = FAIR ? last_wr : 1'b1;
        rd_rdy  = load_en & (~wr_val | rd_pref);
        wr_rdy  = load_en & (~rd_val | ~rd_pref);
        rd_acc  = rd_val & rd_rdy;
        wr_acc  = wr_val & wr_rdy;
    end

    // Output slot and round-robin pointer; payload holds when the slot drains empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            header_out <= '0;
            data_out   <= '0;
            grant_src  <= 1'b0;
            out_val    <= 1'b0;
            last_wr    <= 1'b1;
        end else if (rd_acc) begin
            header_out <= rd_header_in;
            data_out   <= rd_data_in;
            grant_src  <= 1'b0;
            out_val    <= 1'b1;
            last_wr    <= 1'b0;
        end else if (wr_acc) begin
            header_out <= wr_header_in;
            data_out   <= DW'(0);
            grant_src  <= 1'b1;
            out_val    <= 1'b1;
            last_wr    <= 1'b1;
        end else if (out_rdy) begin
            out_val    <= 1'b0;
        end
    end

    logic unused_hw;
    assign unused_hw = ^HW'(0);

endmodule
